ahb_sram_slave: RTL and testbench

//  AHB-Lite slave fronting a word-organised, byte-writable SRAM. Sits behind the bus decoder/mux on
//  the slave side of the existing AHB interface. Adds HSIZE byte-lane writes, configurable wait

---
 rtl/ahb_sram_slave_pkg.sv | 33 +++
 rtl/ahb_sram_core.sv | 21 ++
 rtl/ahb_sram_slave.sv | 92 +++++++++
 tb/tb_ahb_sram_slave.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_pkg: shared AHB-Lite types, slave FSM states and byte-lane helper (S_ERR1/S_ERR2 exist only with AHB_SRAM_ERROR_EN)
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_t;
  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_t;
`ifdef AHB_SRAM_ERROR_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} slv_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} slv_state_t;
`endif
  // Lanes covered by [addr, addr + 2**size), with size clamped to a full word and addr aligned down
  function automatic logic [7:0] byte_en(input logic [2:0] size, input logic [2:0] addr_lsb, input int bytes);
    int lg, n, base;
    lg = (bytes == 8) ? 3 : 2;
    n = 1 << ((int'(size) > lg) ? lg : int'(size));
    base = int'(addr_lsb) & (bytes - 1) & ~(n - 1);
    byte_en = '0;
    for (int i = 0; i < 8; i++) byte_en[i] = (i >= base) && (i < base + n);
  endfunction
endpackage

// File: rtl/ahb_sram_core.sv
// ahb_sram_core: DEPTH x DATA_WIDTH flop array with per-byte write enables and a combinational read port
module ahb_sram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [BYTES-1:0]      be_i,
  input  logic [IW-1:0]         idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  // Byte-lane write; storage is deliberately not reset
  always_ff @(posedge clk_i)
    for (int b = 0; b < BYTES; b++)
      if (we_i && be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with HSIZE byte lanes and wait states; AHB_SRAM_ERROR_EN adds two-cycle ERROR responses
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADY_OUT
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);
  localparam int OW    = LSB + IW;
  slv_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OW-1:0] addr_q;
  logic write_q;
  logic [2:0] size_q;
  logic accept, we;
  logic [7:0] be;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_ok;
  assign accept = HSEL & HREADY & HTRANS[1];
  assign unused_ok = ^{HTRANS[0], HADDR, be};
`ifdef AHB_SRAM_ERROR_EN
  logic err;
  logic [LSB-1:0] align_mask;
  assign align_mask = LSB'((8'd1 << HSIZE) - 8'd1);
  assign err = (|HADDR[ADDR_WIDTH-1:OW]) | (HSIZE > 3'(LSB)) | (|(HADDR[LSB-1:0] & align_mask));
  assign HREADY_OUT = !(state_q == S_DATA && cnt_q != '0) && state_q != S_ERR1;
  assign HRESP = (state_q == S_ERR1 || state_q == S_ERR2) ? RESP_ERROR : RESP_OKAY;
`else
  assign HREADY_OUT = !(state_q == S_DATA && cnt_q != '0);
  assign HRESP = RESP_OKAY;
`endif
  assign HRDATA = (state_q == S_DATA) ? rdata : '0;
  assign we = state_q == S_DATA && cnt_q == '0 && write_q;
  assign be = byte_en(size_q, 3'(addr_q[LSB-1:0]), BYTES);
  // Next state: count down wait states, otherwise follow the accept rule so transfers chain without bubbles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == S_DATA && cnt_q != '0) cnt_d = cnt_q - 4'd1;
`ifdef AHB_SRAM_ERROR_EN
    else if (state_q == S_ERR1) state_d = S_ERR2;
    else if (accept && err) state_d = S_ERR1;
`endif
    else if (accept) begin
      state_d = S_DATA;
      cnt_d = 4'(WAIT_STATES);
    end
    else state_d = S_IDLE;
  end
  // State, wait counter and address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept && HREADY_OUT) begin
        addr_q <= HADDR[OW-1:0];
        write_q <= HWRITE;
        size_q <= HSIZE;
      end
    end
  ahb_sram_core #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_core (
    .clk_i(HCLK),
    .we_i(we),
    .be_i(be[BYTES-1:0]),
    .idx_i(addr_q[OW-1:LSB]),
    .wdata_i(HWDATA),
    .rdata_o(rdata)
  );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: bus-level checks of ahb_sram_slave against a byte-addressed memory model (AHB_SRAM_ERROR_EN selects the error build)
module tb_ahb_sram_slave;
  localparam int AW = 32, DW = 32, DEPTH = 1024, WS = 3;
  localparam int BYTES = DW / 8, SPAN = DEPTH * BYTES, LGB = $clog2(BYTES);
  logic clk = 0, rst_n = 0, hsel = 0, hwrite = 0, hready, hready_out;
  logic [AW-1:0] haddr = '0;
  logic [1:0] htrans = '0, hresp;
  logic [2:0] hsize = '0;
  logic [DW-1:0] hwdata = '0, hrdata;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign hready = hready_out;
  ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp), .HREADY_OUT(hready_out)
  );
  // kind: 0 transfer, 1 IDLE, 2 BUSY, 3 NONSEQ with HSEL low
  typedef struct {
    int kind;
    logic wr;
    logic [AW-1:0] addr;
    logic [2:0] size;
    logic [DW-1:0] data;
  } txn_t;
  logic [7:0] mem_m [int];
  function automatic txn_t mk(int k, logic w, logic [AW-1:0] a, logic [2:0] s, logic [DW-1:0] d);
    txn_t t;
    t.kind = k; t.wr = w; t.addr = a; t.size = s; t.data = d;
    return t;
  endfunction
  function automatic bit is_err(txn_t t);
`ifdef AHB_SRAM_ERROR_EN
    return t.addr >= AW'(SPAN) || int'(t.size) > LGB || (t.addr % (32'd1 << t.size)) != 0;
`else
    return 0;
`endif
  endfunction
  function automatic void wr_model(txn_t t);
    int n, a;
    n = (int'(t.size) > LGB) ? BYTES : (1 << t.size);
    a = int'(t.addr % SPAN);
    a -= a % n;
    for (int b = 0; b < n; b++) mem_m[a + b] = t.data[8*((a + b) % BYTES) +: 8];
  endfunction
  function automatic void rd_exp(input txn_t t, output logic [DW-1:0] e, output logic [DW-1:0] m);
    int w;
    w = int'(t.addr % SPAN);
    w -= w % BYTES;
    e = '0; m = '0;
    for (int b = 0; b < BYTES; b++)
      if (mem_m.exists(w + b)) begin
        e[8*b +: 8] = mem_m[w + b];
        m[8*b +: 8] = 8'hFF;
      end
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  // Drives a pipelined sequence; every cycle compares the bus outputs with what the model predicts
  task automatic run(input txn_t q[$], output int lows);
    int i, cnt, guard;
    bit act, err, rdy;
    txn_t dp;
    logic [DW-1:0] e, m;
    i = 0; cnt = 0; guard = 0; act = 0; err = 0; lows = 0;
    while ((i < q.size() || act) && guard < 10000) begin
      guard++;
      hwdata = (act && dp.wr) ? dp.data : '0;
      if (i < q.size()) begin
        hsel = q[i].kind != 3;
        htrans = q[i].kind == 1 ? 2'b00 : q[i].kind == 2 ? 2'b01 : (act ? 2'b11 : 2'b10);
        haddr = q[i].addr; hwrite = q[i].wr; hsize = q[i].size;
      end else begin
        hsel = 0; htrans = 2'b00;
      end
      @(negedge clk);
      rdy = !act || cnt == 0;
      if (!hready_out) lows++;
      chk("hready_out", 64'(hready_out), 64'(rdy));
      chk("hresp", 64'(hresp), (act && err) ? 64'd1 : 64'd0);
      if (act && !dp.wr && !err && cnt == 0) begin
        rd_exp(dp, e, m);
        chk("hrdata", 64'(hrdata & m), 64'(e));
      end else if (!act || err) chk("hrdata_zero", 64'(hrdata), 64'd0);
      @(posedge clk);
      if (act) begin
        if (cnt == 0) begin
          if (dp.wr && !err) wr_model(dp);
          act = 0;
        end else cnt--;
      end
      if (rdy && i < q.size()) begin
        if (q[i].kind == 0) begin
          dp = q[i]; act = 1; err = is_err(dp); cnt = err ? 1 : WS;
        end
        i++;
      end
      #1;
    end
    hsel = 0; htrans = 2'b00;
    chk("run_done_in_budget", 64'(guard < 10000), 64'd1);
  endtask
  initial begin
    txn_t q[$];
    int lows;
    #12;
    chk("rst_hready_out", 64'(hready_out), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    q = '{mk(0, 1, 32'h10, 3'd2, 32'hDEADBEEF), mk(0, 0, 32'h10, 3'd2, '0)};
    run(q, lows);
    q = '{mk(0, 1, 32'h20, 3'd2, 32'h0), mk(0, 1, 32'h22, 3'd0, 32'h00AA0000),
          mk(0, 1, 32'h20, 3'd1, 32'h00001234), mk(0, 0, 32'h20, 3'd2, '0)};
    run(q, lows);
    q = '{mk(0, 0, 32'h20, 3'd2, '0)};
    run(q, lows);
    chk("single_read_wait_cycles", 64'(lows), 64'(WS));
    q = '{mk(0, 0, 32'h10, 3'd2, '0), mk(0, 0, 32'h14, 3'd2, '0)};
    run(q, lows);
    chk("two_reads_wait_cycles", 64'(lows), 64'(2 * WS));
    q = '{mk(0, 1, 32'h0, 3'd2, 32'hCAFEF00D), mk(0, 1, 32'h8, 3'd2, 32'h01020304), mk(0, 1, 32'hC, 3'd2, 32'h0)};
    run(q, lows);
`ifdef AHB_SRAM_ERROR_EN
    q = '{mk(0, 1, 32'h1000, 3'd2, 32'h0BADBEEF), mk(0, 1, 32'h02, 3'd2, 32'h55555555),
          mk(0, 0, 32'h0, 3'd2, '0), mk(0, 1, 32'h2, 3'd3, 32'h77777777), mk(0, 0, 32'h0, 3'd2, '0)};
    run(q, lows);
    chk("error_seq_wait_cycles", 64'(lows), 64'(3 + WS * 2));
`else
    q = '{mk(0, 1, 32'h1004, 3'd2, 32'h5A5AA5A5), mk(0, 0, 32'h0004, 3'd2, '0),
          mk(0, 1, 32'hA, 3'd2, 32'h99887766), mk(0, 0, 32'h8, 3'd2, '0),
          mk(0, 1, 32'hD, 3'd3, 32'hA1B2C3D4), mk(0, 0, 32'hC, 3'd2, '0)};
    run(q, lows);
`endif
    q = '{mk(0, 1, 32'h40, 3'd2, 32'h11111111)};
    run(q, lows);
    hsel = 1; htrans = 2'b10; haddr = 32'h40; hwrite = 1; hsize = 3'd2;
    @(posedge clk) #1;
    hsel = 0; htrans = 2'b00; hwdata = 32'h22222222;
    @(posedge clk) #1;
    chk("pre_reset_stalled", 64'(hready_out), 64'd0);
    rst_n = 0;
    #1;
    chk("midrst_hready_out", 64'(hready_out), 64'd1);
    chk("midrst_hresp", 64'(hresp), 64'd0);
    chk("midrst_hrdata", 64'(hrdata), 64'd0);
    @(posedge clk) #1;
    chk("midrst_hold_hready_out", 64'(hready_out), 64'd1);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    q = '{mk(0, 0, 32'h40, 3'd2, '0)};
    run(q, lows);
    q.delete();
    for (int a = 0; a < 64; a += BYTES) q.push_back(mk(0, 1, AW'(a), 3'd2, $urandom));
    run(q, lows);
    q.delete();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      q.push_back(mk(r < 6 ? 0 : r - 6, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 63)) | ($urandom_range(0, 5) == 0 ? AW'($urandom_range(1, 3)) << 12 : '0),
                     3'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)), $urandom));
    end
    run(q, lows);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
